// File: rtl/round_key_adder.sv
`default_nettype none
// ============================================================================
// Module   : round_key_adder
// Purpose  : AddRoundKey stage for a block cipher datapath. Holds a bank of
//            round keys and XORs the key selected by the beat's round index
//            onto the incoming state. It has one registered output stage with
//            valid/ready handshaking on both sides.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            key_wr_en/idx/data - round-key bank write port
//            last_idx          - final key index of a block
//            bypass            - forward state unmodified (index still advances)
//            in_valid/in_ready/in_start/in_data   - input beat
//            out_valid/out_ready/out_data/out_idx/out_last - output beat
// Revision : 1.0 - initial release
// ============================================================================
module round_key_adder #(
    parameter  int DATA_W   = 128,
    parameter  int NUM_KEYS = 15,
    localparam int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic [IDX_W-1:0]  last_idx,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_start,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    localparam logic [IDX_W-1:0] c_MAX_IDX  = IDX_W'(NUM_KEYS - 1);
    localparam logic [IDX_W:0]   c_NUM_KEYS = (IDX_W + 1)'(NUM_KEYS);

    logic [DATA_W-1:0] r_bank [NUM_KEYS];
    logic [IDX_W-1:0]  r_rnd_idx;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_out_last;

    logic              w_key_wr_ok;
    logic              w_in_accept;
    logic [IDX_W-1:0]  w_eff_last;
    logic [IDX_W-1:0]  w_used;
    logic [DATA_W-1:0] w_key;
    logic              w_is_last;
    logic [IDX_W-1:0]  w_next_idx;

    // Out-of-range write indices are dropped entirely.
    assign w_key_wr_ok = key_wr_en && ({1'b0, key_wr_idx} < c_NUM_KEYS);

    // The output register can take a new beat when empty or being drained.
    assign in_ready    = !r_out_valid || out_ready;
    assign w_in_accept = in_valid && in_ready;

    // A last_idx beyond the bank depth is clamped to the final bank entry.
    assign w_eff_last = (last_idx > c_MAX_IDX) ? c_MAX_IDX : last_idx;
    assign w_used     = in_start ? '0 : r_rnd_idx;

    // The bank read is taken before any same-cycle write lands, so a
    // concurrent write to the used index is not seen until the next beat.
    assign w_key      = r_bank[w_used];
    assign w_is_last  = (w_used == w_eff_last);

    // Wrap to 0 at the final key. Also wrap when the counter is already past
    // a newly lowered last_idx, so the index can never walk off the bank.
    assign w_next_idx = (w_used >= w_eff_last) ? '0 : (w_used + IDX_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_bank[k] <= '0;
            end
        end else if (w_key_wr_ok) begin
            r_bank[key_wr_idx] <= key_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rnd_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_accept) begin
            r_rnd_idx   <= w_next_idx;
            r_out_valid <= 1'b1;
            r_out_data  <= bypass ? in_data : (in_data ^ w_key);
            r_out_idx   <= w_used;
            r_out_last  <= w_is_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_round_key_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_key_adder
// Purpose  : Self-checking scoreboard bench for round_key_adder. Stimulus tasks
//            push the expected beat when an input beat is issued. A monitor on
//            the falling edge pops and compares each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_key_adder;

    localparam int DW = 128;
    localparam int NK = 15;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_wr_en = 1'b0;
    logic [IW-1:0] key_wr_idx = '0;
    logic [DW-1:0] key_wr_data = '0;
    logic [IW-1:0] last_idx = 4'd10;
    logic          bypass = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    logic [DW-1:0] keys [16];
    int            total = 0;
    int            bad = 0;

    localparam logic [DW-1:0] c_AES_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [DW-1:0] c_AES_PT  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [DW-1:0] c_AES_OUT = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
    localparam logic [DW-1:0] c_ONES    = {DW{1'b1}};
    localparam logic [DW-1:0] c_NEWK    = 128'h0123456789ABCDEF_FEDCBA9876543210;

    round_key_adder #(.DATA_W(DW), .NUM_KEYS(NK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_wr_en  (key_wr_en),
        .key_wr_idx (key_wr_idx),
        .key_wr_data(key_wr_data),
        .last_idx   (last_idx),
        .bypass     (bypass),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_start   (in_start),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: a beat presented with out_ready high at the falling edge is
    // consumed on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got idx %0d required no beat", out_idx);
            end else begin
                mon_e = q.pop_front();
                check("beat_data", out_data, mon_e.d);
                check("beat_idx", DW'(out_idx), DW'(mon_e.i));
                check("beat_last", DW'(out_last), DW'(mon_e.l));
            end
        end
    end

    task automatic wkey(input logic [IW-1:0] idx, input logic [DW-1:0] data);
        @(negedge clk);
        key_wr_en   = 1'b1;
        key_wr_idx  = idx;
        key_wr_data = data;
        @(posedge clk);
        #1;
        key_wr_en = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic st, input logic byp,
                        input logic [DW-1:0] ed, input logic [IW-1:0] ei,
                        input logic el);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_start = st;
        in_data  = d;
        bypass   = byp;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 required 1");
            in_valid = 1'b0;
            return;
        end
        q.push_back('{d: ed, i: ei, l: el});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        logic [DW-1:0] d;
        logic [DW-1:0] held;
        int            n;

        for (int k = 0; k < 16; k++) keys[k] = '0;

        // Reset state
        #2;
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_idx", DW'(out_idx), '0);
        check("rst_out_last", DW'(out_last), '0);
        check("rst_in_ready", DW'(in_ready), DW'(1));
        #20;
        rst_n = 1'b1;

        // Load the bank; index 15 is outside the bank and must be dropped.
        wkey(4'd0, c_AES_KEY);
        keys[0] = c_AES_KEY;
        for (int k = 1; k < NK; k++) begin
            keys[k] = {16{8'hA5 ^ 8'(k)}};
            wkey(IW'(k), keys[k]);
        end
        wkey(4'd15, c_ONES);

        // AES vector, then a full 11-beat block and a wrap to index 0.
        last_idx = 4'd10;
        send(c_AES_PT, 1'b1, 1'b0, c_AES_OUT, 4'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            d = {16{8'h10 + 8'(k)}};
            send(d, 1'b0, 1'b0, d ^ keys[k], IW'(k), (k == 10));
        end
        d = {16{8'h3C}};
        send(d, 1'b0, 1'b0, d ^ keys[0], 4'd0, 1'b0);
        idle(2);

        // Backpressure: output held for 3 cycles, then back-to-back beats.
        out_ready = 1'b0;
        d = {8{16'hBEEF}};
        held = d ^ keys[0];
        send(d, 1'b1, 1'b0, held, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_valid", DW'(out_valid), DW'(1));
            check("stall_in_ready", DW'(in_ready), '0);
            check("stall_out_data", out_data, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            d = {16{8'h50 + 8'(k)}};
            send(d, 1'b0, 1'b0, d ^ keys[k], IW'(k), 1'b0);
            check("b2b_out_valid", DW'(out_valid), DW'(1));
        end

        // Key write in the same cycle as the beat that uses it.
        d = {16{8'h77}};
        send(d, 1'b1, 1'b0, d ^ keys[0], 4'd0, 1'b0);
        key_wr_en   = 1'b1;
        key_wr_idx  = 4'd1;
        key_wr_data = c_NEWK;
        d = {16{8'h78}};
        send(d, 1'b0, 1'b0, d ^ keys[1], 4'd1, 1'b0);
        key_wr_en = 1'b0;
        keys[1]   = c_NEWK;
        d = {16{8'h79}};
        send(d, 1'b1, 1'b0, d ^ keys[0], 4'd0, 1'b0);
        d = {16{8'h7A}};
        send(d, 1'b0, 1'b0, d ^ keys[1], 4'd1, 1'b0);

        // Bypass with an all-ones key: data unchanged, index still advances.
        wkey(4'd0, c_ONES);
        keys[0] = c_ONES;
        d = {4{32'hCAFEF00D}};
        send(d, 1'b1, 1'b1, d, 4'd0, 1'b0);
        d = {4{32'h12345678}};
        send(d, 1'b0, 1'b1, d, 4'd1, 1'b0);

        // last_idx lowered below the running index: use it, then wrap.
        last_idx = 4'd1;
        d = {16{8'h21}};
        send(d, 1'b0, 1'b0, d ^ keys[2], 4'd2, 1'b0);
        d = {16{8'h22}};
        send(d, 1'b0, 1'b0, d ^ keys[0], 4'd0, 1'b0);
        d = {16{8'h23}};
        send(d, 1'b0, 1'b0, d ^ keys[1], 4'd1, 1'b1);
        d = {16{8'h24}};
        send(d, 1'b0, 1'b0, d ^ keys[0], 4'd0, 1'b0);
        idle(2);

        // Reset while a beat at index 5 is held.
        last_idx = 4'd10;
        for (int k = 0; k <= 5; k++) begin
            d = {16{8'h90 + 8'(k)}};
            send(d, (k == 0), 1'b0, d ^ keys[k], IW'(k), 1'b0);
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("held_out_valid", DW'(out_valid), DW'(1));
        check("held_out_idx", DW'(out_idx), DW'(5));
        #2;
        rst_n = 1'b0;
        q.delete();
        for (int k = 0; k < 16; k++) keys[k] = '0;
        #1;
        check("arst_out_valid", DW'(out_valid), '0);
        check("arst_out_idx", DW'(out_idx), '0);
        check("arst_out_data", out_data, '0);
        check("arst_in_ready", DW'(in_ready), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        d = {4{32'h5A5A0F0F}};
        send(d, 1'b0, 1'b0, d ^ keys[0], 4'd0, 1'b0);

        // Drain the scoreboard.
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats outstanding required 0", q.size());
        end
        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/round_key_adder.md
ROUND_KEY_ADDER -- requirements
Module: round_key_adder

Interface
REQ-001 Parameter: DATA_W, 128, state/key width in bits.
REQ-002 Parameter: NUM_KEYS, 15, round-key bank depth; IDX_W = clog2(NUM_KEYS).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: key_wr_en  input  1  round-key bank write strobe.
REQ-006 Port: key_wr_idx  input  IDX_W  bank entry written.
REQ-007 Port: key_wr_data  input  DATA_W  round-key value written.
REQ-008 Port: last_idx  input  IDX_W  final key index of a block (10 for AES-128, 14 for AES-256).
REQ-009 Port: bypass  input  1  1 = pass data unmodified; index still advances.
REQ-010 Port: in_valid  input  1  input beat valid.
REQ-011 Port: in_ready  output  1  block can accept an input beat.
REQ-012 Port: in_start  input  1  beat is round 0 of a new block; qualified by in_valid.
REQ-013 Port: in_data  input  DATA_W  cipher state in.
REQ-014 Port: out_valid  output  1  output beat valid.
REQ-015 Port: out_ready  input  1  downstream accepts output beat.
REQ-016 Port: out_data  output  DATA_W  state XOR selected round key.
REQ-017 Port: out_idx  output  IDX_W  key index used for this beat.
REQ-018 Port: out_last  output  1  beat used key index last_idx.

Function
REQ-019 Beat accepted when in_valid && in_ready; output accepted when out_valid && out_ready.
REQ-020 in_ready = !out_valid || out_ready (combinational); single registered output stage, latency 1 cycle.
REQ-021 Key index used: 0 when in_start=1, else internal counter rnd_idx.
REQ-022 On accept: out_data <= in_data ^ bank[used] (bypass=0) or in_data (bypass=1); out_idx <= used; out_last <= (used == eff_last); out_valid <= 1.
REQ-023 eff_last = min(last_idx, NUM_KEYS-1).
REQ-024 On accept: rnd_idx <= 0 if used == eff_last, else used+1 (wrap-around).
REQ-025 Output registers hold value while out_valid && !out_ready; out_valid clears on output accept with no new input accept.
REQ-026 Simultaneous output accept and input accept: new beat loaded, out_valid stays 1, no bubble.
REQ-027 Key write takes effect next cycle; same-cycle read of the written index returns the old value.
REQ-028 key_wr_idx >= NUM_KEYS: write ignored, no state change.
REQ-029 rnd_idx, bank, outputs unaffected by key writes except bank entry written.
REQ-030 last_idx change mid-block applies from the next accept; rnd_idx > eff_last at accept is treated as used = rnd_idx, then wraps to 0.

Reset
REQ-031 rst_n low: out_valid=0, out_last=0, out_data=0, out_idx=0, rnd_idx=0, all bank entries=0, immediately and asynchronously.
REQ-032 in_ready = 1 during and after reset; first accept after rst_n rises occurs on the first clk edge with in_valid=1.
REQ-033 Reset mid-block discards the held beat; next beat uses index 0 regardless of in_start.

Verification
REQ-034 bank[0]=2B7E151628AED2A6ABF7158809CF4F3C, in_start=1, in_data=3243F6A8885A308D313198A2E0370734 -> next cycle out_data=193DE3BEA0F4E22B9AC68D2AE9F84808, out_idx=0, out_last=0.
REQ-035 last_idx=10, 11 consecutive beats (first with in_start) -> out_idx 0..10, out_last only on idx 10; 12th beat without in_start -> out_idx=0.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable; out_ready=1 with in_valid=1 -> back-to-back beats, no bubble.
REQ-037 key_wr_en to idx 1 in same cycle as beat using idx 1 -> old key applied; next beat using idx 1 -> new key; write to idx 15 (NUM_KEYS=15) -> ignored.
REQ-038 bypass=1 with bank[0]=FF..FF -> out_data=in_data, out_idx advances 0->1.
REQ-039 rst_n pulsed low while out_valid=1 at idx 5 -> out_valid=0 at once; next beat (in_start=0) -> out_idx=0, out_data=in_data ^ 0.
